// File: rtl/uart_rx_deser_fifo_pkg.sv
// Shared UART receive definitions: 8N1 frame constants, receiver FSM
// state encoding, and the bit-timer width with its reload helper.
package uart_rx_deser_fifo_pkg;

    // 8N1 frame format
    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    // Bit timer is wide enough for the largest legal CLKDIV (65535)
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Down-counter reload value for an interval of 'div' clock cycles
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned div);
        return CNT_W'(div - 1);
    endfunction

endpackage

// File: rtl/uart_rx_deser_fifo_axis_sync_fifo.sv
// Single-clock FIFO with an AXI-Stream style read side. The head entry is
// held in a register (registered-read memory) so o_tdata is glitch-free and
// stays put while the consumer stalls. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module axis_sync_fifo #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RX_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_drop,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [RX_SIZE:0]  level
);

    localparam int unsigned DEPTH = 1 << RX_SIZE;
    localparam int unsigned PTR_W = RX_SIZE + 1;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W-1:0]   rptr_nxt;
    logic [RX_SIZE-1:0] waddr;
    logic [RX_SIZE-1:0] raddr_nxt;
    logic [DATA_W-1:0]  head_q;
    logic               full;
    logic               pop;
    logic               push;

    assign level    = wptr - rptr;
    assign o_tvalid = (level != '0);
    assign full     = level[RX_SIZE];
    assign pop      = o_tvalid & o_tready;
    // A full FIFO still takes a byte when the head leaves on the same edge
    assign push     = in_vld & (~full | pop);
    assign in_drop  = in_vld & ~push;

    assign rptr_nxt  = rptr + PTR_W'(pop);
    assign waddr     = wptr[RX_SIZE-1:0];
    assign raddr_nxt = rptr_nxt[RX_SIZE-1:0];
    assign o_tdata   = head_q;

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[waddr] <= in_data;
        end
    end

    // Read and write pointers advance on accepted pop / push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            rptr <= rptr_nxt;
        end
    end

    // Head register: bypass the incoming byte when it lands on the next head
    // slot (push into empty), otherwise fetch the next entry after a pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
        end else if (push && (waddr == raddr_nxt)) begin
            head_q <= in_data;
        end else if (pop) begin
            head_q <= mem[raddr_nxt];
        end
    end

endmodule

// File: rtl/uart_rx_deser_fifo.sv
// UART 8N1 receiver feeding an AXI-Stream FIFO. The serial line is
// synchronized, sampled mid-bit by a down-counting bit timer, deserialized
// LSB first and pushed into axis_sync_fifo. Bad stop bits and bytes lost to
// a full FIFO are reported as single-cycle pulses.
module uart_rx_deser_fifo #(
    parameter int unsigned CLKDIV  = 100,
    parameter int unsigned RX_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [7:0]         o_tdata,
    output logic               o_tvalid,
    input  logic               o_tready,
    output logic               frame_err,
    output logic               overrun,
    output logic [RX_SIZE:0]   level
);

    import uart_rx_deser_fifo_pkg::*;

    localparam logic [CNT_W-1:0]     BIT_RELOAD  = cnt_load(CLKDIV);
    localparam logic [CNT_W-1:0]     HALF_RELOAD = cnt_load(CLKDIV / 2);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST    = BIT_IDX_W'(DATA_BITS - 1);

    logic                  rx_p0;
    logic                  rx_p1;
    logic                  rx_p2;
    logic                  rx_s;
    logic                  rx_fall;
    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  push_vld;
    logic                  drop;

    assign rx_s    = rx_p1;
    assign rx_fall = rx_p2 & ~rx_p1;

    // Two-flop synchronizer plus one history flop for falling-edge detection;
    // all flops reset to the idle-high line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // Receive FSM: centre-samples each bit, assembles the byte, checks stop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state <= START;
                        cnt   <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (rx_s == START_BIT) begin
                        state   <= DATA;
                        cnt     <= BIT_RELOAD;
                        bit_idx <= '0;
                    end else begin
                        // Line went back high before mid-bit: a glitch
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shreg[bit_idx] <= rx_s;
                        cnt            <= BIT_RELOAD;
                        bit_idx        <= bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (rx_s == STOP_BIT) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Hold off until the line is released so a break reports once
                    if (rx_s == STOP_BIT) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Decoded from the stop-bit sample cycle itself so the byte enters the
    // FIFO on the same edge the FSM leaves STOP (one cycle to o_tvalid)
    assign push_vld = (state == STOP) && (cnt == '0) && (rx_s == STOP_BIT);

    // Overrun pulse for a good byte refused by a full FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= drop;
        end
    end

    axis_sync_fifo #(
        .DATA_W  (DATA_BITS),
        .RX_SIZE (RX_SIZE)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_data  (shreg),
        .in_vld   (push_vld),
        .in_drop  (drop),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .level    (level)
    );

endmodule

// File: tb/tb_uart_rx_deser_fifo.sv
// Scoreboard bench for uart_rx_deser_fifo: stimulus pushes expected bytes
// into a queue, a negedge monitor pops and compares each AXI-Stream beat.
module tb_uart_rx_deser_fifo;

    localparam int unsigned CLKDIV  = 100;
    localparam int unsigned RX_SIZE = 4;

    logic               clk;
    logic               rst;
    logic               rx;
    logic [7:0]         o_tdata;
    logic               o_tvalid;
    logic               o_tready;
    logic               frame_err;
    logic               overrun;
    logic [RX_SIZE:0]   level;

    int n_chk  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int beats  = 0;

    logic [7:0] sb [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] exp_b;

    uart_rx_deser_fifo #(
        .CLKDIV  (CLKDIV),
        .RX_SIZE (RX_SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .o_tdata   (o_tdata),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Advance n cycles, landing 2 time units after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CLKDIV);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_v);
    endtask

    // Same frame, but o_tready is high for exactly the stop-bit sample cycle
    // (start sample lands CLKDIV/2+2 cycles into a bit, then every CLKDIV)
    task automatic send_byte_pop(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rx = 1'b1;
        tick(CLKDIV / 2 + 2);
        o_tready = 1'b1;
        tick(1);
        o_tready = 1'b0;
        tick(CLKDIV - CLKDIV / 2 - 3);
    endtask

    // Monitor: beat scoreboard, flag pulse counters, stall stability
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (prev_stall) begin
                chk("hold_tvalid", int'(o_tvalid), 1);
                chk("hold_tdata", int'(o_tdata), int'(prev_data));
            end
            if (o_tvalid && o_tready) begin
                beats++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_beat: actual=0x%02h required=none", o_tdata);
                end else begin
                    exp_b = sb.pop_front();
                    chk("tdata", int'(o_tdata), int'(exp_b));
                end
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
        end
    end

    initial begin
        int fe0;
        int ov0;
        int b0;
        rst      = 1'b0;
        rx       = 1'b1;
        o_tready = 1'b1;

        // Reset state
        tick(5);
        chk("rst_tvalid", int'(o_tvalid), 0);
        chk("rst_tdata", int'(o_tdata), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b1;
        tick(20);

        // Single byte 0x55 with consumer ready
        fe0 = fe_cnt; ov0 = ov_cnt; b0 = beats;
        sb.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        tick(20);
        chk("b55_beats", beats - b0, 1);
        chk("b55_frame_err", fe_cnt - fe0, 0);
        chk("b55_overrun", ov_cnt - ov0, 0);

        // Back-to-back frames, all-zero and all-one and mixed patterns
        b0 = beats;
        sb.push_back(8'h00); send_byte(8'h00, 1'b1);
        sb.push_back(8'hFF); send_byte(8'hFF, 1'b1);
        sb.push_back(8'hC3); send_byte(8'hC3, 1'b1);
        tick(20);
        chk("b2b_beats", beats - b0, 3);
        chk("b2b_sb_empty", sb.size(), 0);

        // Fill with consumer stalled; 17th byte overruns
        o_tready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(8'(i));
            send_byte(8'(i), 1'b1);
            if (i == 15) chk("fill_level16", int'(level), 16);
        end
        tick(5);
        chk("fill_level_after17", int'(level), 16);
        chk("fill_overrun", ov_cnt - ov0, 1);
        chk("fill_tdata_head", int'(o_tdata), 0);
        o_tready = 1'b1;
        tick(40);
        chk("drain_level", int'(level), 0);
        chk("drain_sb_empty", sb.size(), 0);

        // Full FIFO, push coinciding with a pop is accepted
        o_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'h40 + 8'(i));
            send_byte(8'h40 + 8'(i), 1'b1);
        end
        chk("full2_level", int'(level), 16);
        ov0 = ov_cnt; b0 = beats;
        sb.push_back(8'h50);
        send_byte_pop(8'h50);
        tick(5);
        chk("coinc_level", int'(level), 16);
        chk("coinc_overrun", ov_cnt - ov0, 0);
        chk("coinc_beats", beats - b0, 1);
        o_tready = 1'b1;
        tick(40);
        chk("coinc_drain_sb_empty", sb.size(), 0);
        chk("coinc_drain_level", int'(level), 0);

        // Bad stop bit followed by a long break, then a good byte
        fe0 = fe_cnt; b0 = beats;
        send_byte(8'hA5, 1'b0);
        tick(300);
        rx = 1'b1;
        tick(200);
        chk("break_frame_err", fe_cnt - fe0, 1);
        chk("break_beats", beats - b0, 0);
        chk("break_level", int'(level), 0);
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        tick(20);
        chk("after_break_beats", beats - b0, 1);

        // Short low glitch: nothing happens
        fe0 = fe_cnt; ov0 = ov_cnt; b0 = beats;
        rx = 1'b0;
        tick(30);
        rx = 1'b1;
        tick(200);
        chk("glitch_beats", beats - b0, 0);
        chk("glitch_frame_err", fe_cnt - fe0, 0);
        chk("glitch_overrun", ov_cnt - ov0, 0);
        chk("glitch_level", int'(level), 0);

        // Reset mid-frame with a byte waiting in the FIFO
        o_tready = 1'b0;
        send_byte(8'h77, 1'b1);
        tick(5);
        chk("pre_rst_level", int'(level), 1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        tick(CLKDIV / 2);
        rst = 1'b0;
        #1;
        chk("midrst_tvalid", int'(o_tvalid), 0);
        chk("midrst_tdata", int'(o_tdata), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_overrun", int'(overrun), 0);
        tick(10);
        rst = 1'b1;
        o_tready = 1'b1;
        b0 = beats;
        tick(CLKDIV / 2 - 10 + 5 * CLKDIV);
        tick(100);
        chk("post_rst_no_partial", beats - b0, 0);
        sb.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        tick(20);
        chk("post_rst_beats", beats - b0, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser_fifo.md
UART_RX_DESER_FIFO -- requirements
Module: uart_rx_deser_fifo

Interface
REQ-001 The block SHALL expose parameter CLKDIV, default 100: clock cycles per UART bit; legal range 4 to 65535.
REQ-002 The block SHALL expose parameter RX_SIZE, default 4: log2 of FIFO depth (depth = 2^RX_SIZE).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous UART serial line, idle high.
REQ-006 The block SHALL have port o_tdata, output, 8 bits: AXI-Stream received byte.
REQ-007 The block SHALL have port o_tvalid, output, 1 bit: AXI-Stream valid.
REQ-008 The block SHALL have port o_tready, input, 1 bit: AXI-Stream ready from the consumer.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 The block SHALL have port level, output, RX_SIZE+1 bits: current FIFO occupancy.

Function
REQ-012 The frame format SHALL be fixed at 8N1: 1 start bit (0), 8 data bits LSB first, no parity, 1 stop bit (1).
REQ-013 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value.
REQ-014 The receive FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH; a bit counter SHALL reload to CLKDIV-1 after each sample.
REQ-015 In IDLE, a synchronized 1->0 transition SHALL move the FSM to START with the bit counter loaded to (CLKDIV/2)-1 (integer division).
REQ-016 In START, at counter 0, the FSM SHALL go to DATA if the sample is 0; otherwise it SHALL treat the event as a glitch and return to IDLE with no output and no flag.
REQ-017 In DATA, at each counter 0, the FSM SHALL shift the sample into bit position 0..7 in order; after the 8th sample it SHALL go to STOP.
REQ-018 In STOP, at counter 0, a sample of 1 SHALL push the byte and return to IDLE.
REQ-019 In STOP, at counter 0, a sample of 0 SHALL pulse frame_err, discard the byte and go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL return to IDLE only after the synchronized rx reads 1, so a break condition yields exactly one frame_err.
REQ-021 The FIFO SHALL hold 2^RX_SIZE entries and use RX_SIZE+1-bit read/write pointers that wrap modulo 2^(RX_SIZE+1); level = wptr - rptr.
REQ-022 A pop SHALL occur when o_tvalid and o_tready are both high; o_tvalid SHALL equal (level != 0); o_tdata SHALL show the head entry.
REQ-023 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise the byte SHALL be dropped and overrun SHALL pulse.
REQ-024 A push into an empty FIFO SHALL raise o_tvalid on the next cycle (1-cycle latency from the stop-bit sample cycle).
REQ-025 o_tdata and o_tvalid SHALL remain stable while o_tvalid is high and o_tready is low.

Reset
REQ-026 Reset assertion SHALL immediately force: FSM = IDLE, counters = 0, pointers = 0, level = 0, o_tvalid = 0, o_tdata = 0, frame_err = 0, overrun = 0, synchronizer = 1.
REQ-027 After reset deasserts in the middle of a frame, the block SHALL not emit a partial byte; it SHALL resynchronize on the next 1->0 edge seen from IDLE.

Structure
REQ-028 FSM state encodings and the 8N1 constants (data bits = 8, start bit value, stop bit value) SHALL reside in a shared uart package.
REQ-029 The FIFO SHALL be a separate sub-module, axis_sync_fifo, parameterized by width (8) and RX_SIZE, with a registered-read memory and no inference of vendor primitives.

Verification
REQ-030 With CLKDIV=100 and RX_SIZE=4, a bench driving 0x55 with 100-cycle bits and o_tready=1 SHALL observe one o_tvalid beat carrying 0x55, with frame_err=0 and overrun=0.
REQ-031 A bench holding o_tready=0 while sending 17 bytes 0x00..0x10 SHALL observe level=16 and a single overrun pulse on the 17th byte; draining SHALL return 0x00..0x0F in order.
REQ-032 A bench sending 0xA5 with a stop bit of 0, followed by 300 cycles of rx low, SHALL observe exactly one frame_err pulse and no push; a following 0x3C SHALL be received correctly.
REQ-033 A bench driving a 30-cycle low glitch on rx SHALL observe no push and no flag.
REQ-034 A bench with the FIFO full and o_tready=1, where a push coincides with a pop, SHALL observe the push accepted, no overrun, and level staying at 16.
REQ-035 A bench asserting rst during the 4th data bit of 0xFF SHALL observe all outputs at reset values; after release, a following 0x81 SHALL be the only byte delivered.
